// File: rtl/ahb_master_alu_reg_pipelined.sv
// Pipelined AHB-Lite master executing 64-bit commands against an 8x32 register
// file and a small ALU; supports incrementing bursts, wait states and ERROR abort.

module ahb_master_alu_reg_pipelined_rf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [2:0]  wa,
    input  logic [31:0] wd,
    input  logic [2:0]  ra1,
    input  logic [2:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] registers [0:7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) registers[i] <= '0;
        end else if (we) begin
            registers[wa] <= wd;
        end
    end

    assign rd1 = registers[ra1];
    assign rd2 = registers[ra2];
endmodule

module ahb_master_alu_reg_pipelined (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [63:0] cpu_inst,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [31:0] HRDATA,
    output logic [31:0] HADDR,
    output logic [2:0]  HBURST,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    output logic [1:0]  dbg_state
);
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_BURST = 2'd2,
        S_DATA  = 2'd3
    } state_t;

    state_t state;

    // Command whose beat is currently in its address phase.
    logic       a_register;
    logic       a_rw;
    logic [2:0] a_rr1;
    logic [2:0] a_rr2;
    logic [2:0] a_wr;
    logic [2:0] a_op;
    logic [7:0] beats_left;

    // Beat currently in its data phase.
    logic        d_register;
    logic        d_rw;
    logic [2:0]  d_wr;
    logic [31:0] d_y;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_y;
    logic        RegWrite;
    logic [31:0] WriteData;
    logic [1:0]  type_data;
    logic        data_phase;
    logic        addr_phase;
    logic        new_cmd;
    logic [7:0]  first_beats_m1;
    logic        unused_rsvd;

    ahb_master_alu_reg_pipelined_rf rf (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .we    (RegWrite),
        .wa    (d_wr),
        .wd    (WriteData),
        .ra1   (a_rr1),
        .ra2   (a_rr2),
        .rd1   (op_a),
        .rd2   (op_b)
    );

    always_comb begin
        alu_y = op_a;
        case (a_op)
            3'd0: alu_y = op_a + op_b;
            3'd1: alu_y = op_a - op_b;
            3'd2: alu_y = op_a & op_b;
            3'd3: alu_y = op_a | op_b;
            3'd4: alu_y = op_a ^ op_b;
            3'd5: alu_y = op_a << op_b[4:0];
            3'd6: alu_y = op_a * op_b;
            default: alu_y = op_a;
        endcase
    end

    assign data_phase = (state == S_BURST) || (state == S_DATA);
    assign addr_phase = (state == S_ADDR) || (state == S_BURST);
    assign new_cmd    = cpu_inst[7] && ((state == S_IDLE) || (state == S_DATA));
    assign first_beats_m1 = ((cpu_inst[3:1] != 3'd0) && (cpu_inst[15:8] != 8'd0))
                          ? (cpu_inst[15:8] - 8'd1) : 8'd0;
    assign unused_rsvd = ^cpu_inst[17:16];

    // Load (Register=0,rw=0) and ALU store (Register=1,rw=1) are the writing modes.
    assign type_data = {d_register, d_rw};
    assign RegWrite  = data_phase && HREADY && !HRESP && (d_register == d_rw);
    assign WriteData = d_register ? d_y : HRDATA;
    assign dbg_state = state;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= S_IDLE;
            HADDR      <= '0;
            HBURST     <= '0;
            HSIZE      <= '0;
            HTRANS     <= TR_IDLE;
            HWRITE     <= 1'b0;
            HWDATA     <= '0;
            a_register <= 1'b0;
            a_rw       <= 1'b0;
            a_rr1      <= '0;
            a_rr2      <= '0;
            a_wr       <= '0;
            a_op       <= '0;
            beats_left <= '0;
            d_register <= 1'b0;
            d_rw       <= 1'b0;
            d_wr       <= '0;
            d_y        <= '0;
        end else if (HREADY) begin
            if (data_phase && HRESP) begin
                // ERROR cancels the current beat and any beats not yet transferred.
                HTRANS     <= TR_IDLE;
                beats_left <= '0;
                state      <= S_IDLE;
            end else if (addr_phase) begin
                d_register <= a_register;
                d_rw       <= a_rw;
                d_wr       <= a_wr;
                d_y        <= alu_y;
                if (a_register != a_rw) begin
                    HWDATA <= a_register ? alu_y : op_a;
                end
                if (beats_left != 8'd0) begin
                    HADDR      <= HADDR + (32'd1 << HSIZE);
                    HTRANS     <= TR_SEQ;
                    beats_left <= beats_left - 8'd1;
                    state      <= S_BURST;
                end else begin
                    HTRANS <= TR_IDLE;
                    state  <= S_DATA;
                end
            end else if (new_cmd) begin
                HADDR      <= cpu_inst[63:32];
                HBURST     <= cpu_inst[3:1];
                HSIZE      <= cpu_inst[6:4];
                HWRITE     <= cpu_inst[0];
                HTRANS     <= TR_NONSEQ;
                a_register <= cpu_inst[18];
                a_rr1      <= cpu_inst[21:19];
                a_rr2      <= cpu_inst[24:22];
                a_wr       <= cpu_inst[27:25];
                a_op       <= cpu_inst[30:28];
                a_rw       <= cpu_inst[31];
                beats_left <= first_beats_m1;
                state      <= S_ADDR;
            end else begin
                HTRANS <= TR_IDLE;
                state  <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_ahb_master_alu_reg_pipelined.sv
// Bench for ahb_master_alu_reg_pipelined: directed scenarios plus random commands
// checked against a plain-arithmetic register-file/ALU model.

module tb_ahb_master_alu_reg_pipelined;
  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic [63:0] cpu_inst = '0;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;
  logic [31:0] HRDATA = '0;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [2:0]  HBURST;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [1:0]  dbg_state;
  logic        HWRITE;

  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] model_rf [0:7];

  always #5 HCLK = ~HCLK;

  ahb_master_alu_reg_pipelined dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .cpu_inst  (cpu_inst),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .HADDR     (HADDR),
    .HBURST    (HBURST),
    .HSIZE     (HSIZE),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .dbg_state (dbg_state)
  );

  task automatic tick();
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rf(input string tag);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s_r%0d", tag, k), dut.rf.registers[k], model_rf[k]);
  endtask

  function automatic logic [63:0] mk_cmd(input bit work, input bit hwrite, input logic [2:0] burst,
                                         input logic [2:0] size, input logic [7:0] blen,
                                         input bit regsel, input logic [2:0] rr1, input logic [2:0] rr2,
                                         input logic [2:0] wr, input logic [2:0] op, input bit rw,
                                         input logic [31:0] addr);
    logic [63:0] c;
    c = '0;
    c[0] = hwrite;  c[3:1] = burst;  c[6:4] = size;  c[7] = work;  c[15:8] = blen;
    c[18] = regsel; c[21:19] = rr1;  c[24:22] = rr2; c[27:25] = wr; c[30:28] = op;
    c[31] = rw;     c[63:32] = addr;
    return c;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b[4:0];
      3'd6: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      default: return a;
    endcase
  endfunction

  function automatic int beats_of(input logic [63:0] c);
    return ((c[3:1] != 3'd0) && (c[15:8] != 8'd0)) ? int'(c[15:8]) : 1;
  endfunction

  // Runs one command from its sampling edge through its last data phase.
  task automatic run_cmd(input string tag, input logic [63:0] cmd, input logic [63:0] next_cmd,
                         input bit chained, input int ws_beat, input int err_beat,
                         input bit rd_rand, input logic [31:0] rd_val, output bit started_next);
    int n;
    int reps;
    logic [31:0] base, step, hr, y, exp_wd;
    logic [2:0] wr;
    bit load, store, send;
    load  = !cmd[18] && !cmd[31];
    store = cmd[18] && cmd[31];
    send  = cmd[18] != cmd[31];
    n = beats_of(cmd);
    base = cmd[63:32];
    step = 32'd1 << cmd[6:4];
    wr = cmd[27:25];
    started_next = 1'b0;
    if (!chained) begin
      cpu_inst = cmd; HREADY = 1'b1; HRESP = 1'b0;
      tick();
    end
    cpu_inst = '0;
    check({tag, "_htrans_a0"}, 32'(HTRANS), 32'd2);
    check({tag, "_haddr_a0"}, HADDR, base);
    check({tag, "_hwrite"}, 32'(HWRITE), 32'(cmd[0]));
    check({tag, "_hsize"}, 32'(HSIZE), 32'(cmd[6:4]));
    check({tag, "_hburst"}, 32'(HBURST), 32'(cmd[3:1]));
    tick();
    for (int i = 0; i < n; i++) begin
      y = ref_alu(cmd[30:28], model_rf[cmd[21:19]], model_rf[cmd[24:22]]);
      exp_wd = cmd[18] ? y : model_rf[cmd[21:19]];
      hr = rd_rand ? $urandom : rd_val;
      HRDATA = hr;
      reps = (i == ws_beat) ? 3 : 1;
      for (int w = 0; w < reps; w++) begin
        HREADY = (w == reps - 1);
        check($sformatf("%s_htrans_b%0d", tag, i), 32'(HTRANS), (i + 1 < n) ? 32'd3 : 32'd0);
        if (i + 1 < n) check($sformatf("%s_haddr_b%0d", tag, i + 1), HADDR, base + 32'(i + 1) * step);
        if (send) check($sformatf("%s_hwdata_b%0d", tag, i), HWDATA, exp_wd);
        if (w < reps - 1) check($sformatf("%s_wait_r%0d", tag, wr), dut.rf.registers[wr], model_rf[wr]);
        if (i == err_beat && w == reps - 1) HRESP = 1'b1;
        if (i == n - 1 && w == reps - 1) cpu_inst = next_cmd;
        tick();
      end
      HREADY = 1'b1;
      if (i == err_beat) begin
        HRESP = 1'b0;
        cpu_inst = '0;
        check({tag, "_err_htrans"}, 32'(HTRANS), 32'd0);
        check({tag, "_err_state"}, 32'(dbg_state), 32'd0);
        check_rf({tag, "_err"});
        return;
      end
      if (load) model_rf[wr] = hr;
      else if (store) model_rf[wr] = y;
    end
    started_next = next_cmd[7];
    if (!started_next) begin
      cpu_inst = '0;
      check({tag, "_end_htrans"}, 32'(HTRANS), 32'd0);
      check({tag, "_end_state"}, 32'(dbg_state), 32'd0);
    end
    check_rf(tag);
  endtask

  logic [63:0] cmds [0:23];
  int ws_a [0:23];
  int er_a [0:23];

  initial begin
    bit sn;
    bit chain;
    int mode;
    int nb;
    logic [2:0] rr1, rr2, wr, burst;
    logic [63:0] nxt;

    for (int k = 0; k < 8; k++) model_rf[k] = '0;

    // Reset state
    #1 HRESETn = 1'b0;
    #1;
    check("rst_htrans", 32'(HTRANS), 32'd0);
    check("rst_haddr", HADDR, 32'd0);
    check("rst_hwdata", HWDATA, 32'd0);
    check("rst_hwrite", 32'(HWRITE), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check_rf("rst");
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick();

    // T1 load 10 into r0, idle cycle, send r0 to address 10
    run_cmd("t1_load", mk_cmd(1, 0, 3'd0, 3'd2, 8'd0, 0, 3'd0, 3'd0, 3'd0, 3'd0, 0, 32'h0),
            '0, 0, -1, -1, 0, 32'd10, sn);
    check("t1_r0_is_10", dut.rf.registers[0], 32'd10);
    tick();
    run_cmd("t1_send", mk_cmd(1, 1, 3'd0, 3'd2, 8'd0, 0, 3'd0, 3'd0, 3'd0, 3'd0, 1, 32'd10),
            '0, 0, -1, -1, 0, 32'd0, sn);

    // T2 ALU: r1=15, r2=r0*r1, send r0+r1, send r2
    run_cmd("t2_load", mk_cmd(1, 0, 3'd0, 3'd2, 8'd0, 0, 3'd0, 3'd0, 3'd1, 3'd0, 0, 32'h4),
            '0, 0, -1, -1, 0, 32'd15, sn);
    tick();
    run_cmd("t2_mul", mk_cmd(1, 0, 3'd0, 3'd2, 8'd0, 1, 3'd0, 3'd1, 3'd2, 3'd6, 1, 32'h8),
            '0, 0, -1, -1, 1, 32'd0, sn);
    check("t2_r2_is_150", dut.rf.registers[2], 32'd150);
    tick();
    run_cmd("t2_add", mk_cmd(1, 1, 3'd0, 3'd2, 8'd0, 1, 3'd0, 3'd1, 3'd0, 3'd0, 0, 32'hC),
            '0, 0, -1, -1, 1, 32'd0, sn);
    run_cmd("t2_send", mk_cmd(1, 1, 3'd0, 3'd2, 8'd0, 0, 3'd2, 3'd0, 3'd0, 3'd0, 1, 32'h10),
            '0, 0, -1, -1, 1, 32'd0, sn);

    // T3 wait states in a send and in a load
    run_cmd("t3_send_ws", mk_cmd(1, 1, 3'd0, 3'd2, 8'd0, 0, 3'd2, 3'd0, 3'd0, 3'd0, 1, 32'h20),
            '0, 0, 0, -1, 1, 32'd0, sn);
    run_cmd("t3_load_ws", mk_cmd(1, 0, 3'd0, 3'd2, 8'd0, 0, 3'd0, 3'd0, 3'd3, 3'd0, 0, 32'h24),
            '0, 0, 0, -1, 0, 32'd77, sn);

    // T5 work=0 for three cycles, then back-to-back commands
    cpu_inst = mk_cmd(0, 1, 3'd0, 3'd2, 8'd0, 0, 3'd1, 3'd0, 3'd0, 3'd0, 1, 32'h30);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t5_idle_%0d", k), 32'(HTRANS), 32'd0);
    end
    nxt = mk_cmd(1, 1, 3'd0, 3'd2, 8'd0, 1, 3'd1, 3'd3, 3'd0, 3'd4, 0, 32'h40);
    run_cmd("t5_a", mk_cmd(1, 1, 3'd0, 3'd2, 8'd0, 0, 3'd1, 3'd0, 3'd0, 3'd0, 1, 32'h30),
            nxt, 0, -1, -1, 1, 32'd0, sn);
    run_cmd("t5_b", nxt, '0, sn, -1, -1, 1, 32'd0, sn);

    // T6 bursts: full burst, error on beat 2, load burst error, length 0
    run_cmd("t6_burst", mk_cmd(1, 1, 3'd1, 3'd3, 8'd3, 0, 3'd2, 3'd0, 3'd0, 3'd0, 1, 32'h0),
            '0, 0, -1, -1, 1, 32'd0, sn);
    tick();
    run_cmd("t6_err", mk_cmd(1, 1, 3'd1, 3'd3, 8'd3, 0, 3'd2, 3'd0, 3'd0, 3'd0, 1, 32'h0),
            '0, 0, -1, 1, 1, 32'd0, sn);
    tick();
    run_cmd("t6_lderr", mk_cmd(1, 0, 3'd3, 3'd2, 8'd2, 0, 3'd0, 3'd0, 3'd5, 3'd0, 0, 32'h100),
            '0, 0, -1, 0, 1, 32'd0, sn);
    tick();
    run_cmd("t6_len0", mk_cmd(1, 1, 3'd3, 3'd2, 8'd0, 0, 3'd3, 3'd0, 3'd0, 3'd0, 1, 32'h200),
            '0, 0, -1, -1, 1, 32'd0, sn);

    // T4 reset mid-burst
    cpu_inst = mk_cmd(1, 1, 3'd1, 3'd2, 8'd4, 0, 3'd1, 3'd0, 3'd0, 3'd0, 1, 32'h300);
    tick();
    cpu_inst = '0;
    tick();
    #1 HRESETn = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) model_rf[k] = '0;
    check("t4_htrans", 32'(HTRANS), 32'd0);
    check("t4_haddr", HADDR, 32'd0);
    check("t4_hwdata", HWDATA, 32'd0);
    check("t4_hsize", 32'(HSIZE), 32'd0);
    check("t4_hburst", 32'(HBURST), 32'd0);
    check("t4_state", 32'(dbg_state), 32'd0);
    check_rf("t4");
    tick();
    HRESETn = 1'b1;
    tick();
    check("t4_after_htrans", 32'(HTRANS), 32'd0);

    // Random commands
    for (int k = 0; k < 24; k++) begin
      mode = $urandom_range(0, 3);
      if (mode == 2) begin
        rr1 = 3'($urandom_range(0, 3)); rr2 = 3'($urandom_range(0, 3)); wr = 3'($urandom_range(4, 7));
      end else begin
        rr1 = 3'($urandom_range(0, 7)); rr2 = 3'($urandom_range(0, 7)); wr = 3'($urandom_range(0, 7));
      end
      burst = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'd0;
      cmds[k] = mk_cmd(1, (mode == 1) || (mode == 3), burst, 3'($urandom_range(0, 2)),
                       8'($urandom_range(0, 4)), mode >= 2, rr1, rr2, wr, 3'($urandom_range(0, 7)),
                       (mode == 1) || (mode == 2), $urandom);
      nb = beats_of(cmds[k]);
      ws_a[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      er_a[k] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
    end
    chain = 1'b0;
    for (int k = 0; k < 24; k++) begin
      nxt = '0;
      if (k < 23 && cmds[k][18] != cmds[k][31] && er_a[k] < 0 && $urandom_range(0, 1) == 1)
        nxt = cmds[k + 1];
      run_cmd($sformatf("rnd%0d", k), cmds[k], nxt, chain, ws_a[k], er_a[k], 1, 32'd0, sn);
      chain = sn;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
